prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader.
// Parses framed bytes into program-memory writes
// while holding the CPU in reset.
//
// Ports:
//   clock, reset       : clock, sync active-high reset
//   in_data/valid/ready: byte input handshake
//   prog_we/addr/data  : program-memory write port
//   cpu_hold           : CPU reset hold during a frame
//   done, err          : sticky status of last frame
//
// Build option: LOADER_CHECKSUM_EN adds a trailing
// checksum byte per frame and enables err.
module prog_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        prog_we,
    output logic [11:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_FIN
    } state_t;
`endif

    localparam logic [7:0] HDR = 8'hA5;

    state_t      r_state;
    state_t      w_next;
    logic        w_ready;
    logic        w_acc;
    logic        w_last;
    logic [11:0] r_addr;
    logic [8:0]  r_cnt;
    logic        r_we;
    logic [11:0] r_pa;
    logic [7:0]  r_pd;
    logic        r_hold;
    logic        r_done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    logic        r_csum_ok;
    logic        r_err;
`endif

    // FIN is the only state that refuses bytes.
    assign w_ready = (r_state != S_FIN) & ~reset;
    assign w_acc   = in_valid & w_ready;
    // Counter holds bytes still owed; 1 means
    // the byte being accepted is the last one.
    assign w_last  = (r_cnt == 9'd1);

    assign in_ready  = w_ready;
    assign prog_we   = r_we;
    assign prog_addr = r_pa;
    assign prog_data = r_pd;
    assign cpu_hold  = r_hold;
    assign done      = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && in_data == HDR) begin
                    w_next = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (w_acc) begin
                    w_next = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (w_acc) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_acc) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_acc && w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_acc) begin
                    w_next = S_FIN;
                end
            end
`endif
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr <= 12'h000;
            r_cnt  <= 9'd0;
            r_we   <= 1'b0;
            r_pa   <= 12'h000;
            r_pd   <= 8'h00;
            r_hold <= 1'b0;
            r_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= 8'h00;
            r_csum_ok <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc && in_data == HDR) begin
                        r_hold <= 1'b1;
                        r_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_err     <= 1'b0;
                        r_sum     <= 8'h00;
                        r_csum_ok <= 1'b0;
`endif
                    end
                end
                S_ADDR_HI: begin
                    if (w_acc) begin
                        r_addr[11:8] <= in_data[3:0];
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                    end
                end
                S_ADDR_LO: begin
                    if (w_acc) begin
                        r_addr[7:0] <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                    end
                end
                S_LEN: begin
                    if (w_acc) begin
                        r_cnt <= {1'b0, in_data} + 9'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_we   <= 1'b1;
                        r_pa   <= r_addr;
                        r_pd   <= in_data;
                        // 12-bit wrap is intended.
                        r_addr <= r_addr + 12'd1;
                        r_cnt  <= r_cnt - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_acc) begin
                        r_csum_ok <= (in_data == r_sum);
                    end
                end
`endif
                S_FIN: begin
                    r_hold <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    r_done <= r_csum_ok;
                    r_err  <= ~r_csum_ok;
`else
                    r_done <= 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench
// for prog_loader (both checksum builds).
module tb_prog_loader;

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        prog_we;
    logic [11:0] prog_addr;
    logic [7:0]  prog_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  dbuf[256];

    prog_loader dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (prog_we) begin
            wa.push_back(prog_addr);
            wd.push_back(prog_data);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h",
                     tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
        end
    endtask

    // Called at a negedge; returns at the
    // negedge after the byte transferred.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (n >= 8) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [11:0] a,
                             input logic [3:0]  junk,
                             input logic [7:0]  len,
                             input bit          gap,
                             input logic [7:0]  cx);
        logic [7:0] s;
        logic [7:0] hi;
        hi = {junk, a[11:8]};
        s  = hi + a[7:0] + len;
        send(8'hA5);
        send(hi);
        send(a[7:0]);
        send(len);
        for (int i = 0; i <= int'(len); i++) begin
            if (gap) idle(1);
            send(dbuf[i]);
            s = s + dbuf[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send(s ^ cx);
`else
        s = s ^ cx;
`endif
    endtask

    task automatic chk_fin(input string tag);
        chk({tag, "_fin_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_fin_rdy"}, 32'(in_ready), 32'd0);
        @(negedge clock);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic chk_wr(input string tag,
                          input logic [11:0] a,
                          input int n);
        int bad;
        logic [11:0] ea;
        bad = 0;
        chk({tag, "_nwr"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            ea = a + 12'(i);
            if (wa[i] !== ea || wd[i] !== dbuf[i]) begin
                bad++;
            end
        end
        chk({tag, "_wrbad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran too long");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(2);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(prog_we), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'h000);
        chk("rst_data", 32'(prog_data), 32'h00);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        idle(1);

        // Basic three-byte frame.
        wa.delete(); wd.delete();
        dbuf[0] = 8'h4A; dbuf[1] = 8'hC3; dbuf[2] = 8'h7D;
        run_frame(12'h010, 4'h0, 8'h02, 1'b0, 8'h00);
        chk_fin("f1");
        chk("f1_done", 32'(done), 32'd1);
        chk("f1_err", 32'(err), 32'd0);
        chk_wr("f1", 12'h010, 3);
        chk("f1_addr_hold", 32'(prog_addr), 32'h012);
        chk("f1_data_hold", 32'(prog_data), 32'h7D);

        // Address wrap 0xFFF -> 0x000.
        wa.delete(); wd.delete();
        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        run_frame(12'hFFF, 4'h0, 8'h01, 1'b0, 8'h00);
        chk_fin("f2");
        chk("f2_done", 32'(done), 32'd1);
        chk_wr("f2", 12'hFFF, 2);
        if (wa.size() == 2) begin
            chk("f2_wrap", 32'(wa[1]), 32'h000);
        end else begin
            chk("f2_wrap_cnt", 32'(wa.size()), 32'd2);
        end

        // Garbage before header; junk high nibble.
        wa.delete(); wd.delete();
        send(8'h00);
        send(8'hFF);
        idle(2);
        chk("gb_nwr", 32'(wa.size()), 32'd0);
        chk("gb_hold", 32'(cpu_hold), 32'd0);
        chk("gb_done", 32'(done), 32'd1);
        dbuf[0] = 8'h9E; dbuf[1] = 8'h01;
        run_frame(12'h3C0, 4'hC, 8'h01, 1'b1, 8'h00);
        chk_fin("f3");
        chk("f3_done", 32'(done), 32'd1);
        chk_wr("f3", 12'h3C0, 2);

        // Reset after second data byte.
        wa.delete(); wd.delete();
        send(8'hA5);
        chk("rm_done_clr", 32'(done), 32'd0);
        chk("rm_hold_set", 32'(cpu_hold), 32'd1);
        send(8'h00);
        send(8'h20);
        send(8'h05);
        dbuf[0] = 8'h01; dbuf[1] = 8'h02;
        send(dbuf[0]);
        send(dbuf[1]);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h03;
        @(negedge clock);
        chk("rm_rst_rdy", 32'(in_ready), 32'd0);
        chk("rm_rst_hold", 32'(cpu_hold), 32'd0);
        chk("rm_rst_we", 32'(prog_we), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        idle(3);
        send(8'h04);
        send(8'h05);
        idle(2);
        chk_wr("rm", 12'h020, 2);
        chk("rm_hold", 32'(cpu_hold), 32'd0);
        chk("rm_done", 32'(done), 32'd0);
        chk("rm_err", 32'(err), 32'd0);

        // 256 bytes with in_valid every other cycle.
        wa.delete(); wd.delete();
        for (int i = 0; i < 256; i++) begin
            dbuf[i] = 8'(i) ^ 8'h5A;
        end
        run_frame(12'hF80, 4'h0, 8'hFF, 1'b1, 8'h00);
        chk_fin("f4");
        chk("f4_done", 32'(done), 32'd1);
        chk_wr("f4", 12'hF80, 256);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: write kept, err set.
        wa.delete(); wd.delete();
        dbuf[0] = 8'h55;
        run_frame(12'h000, 4'h0, 8'h00, 1'b0, 8'h55);
        chk_fin("f5");
        chk("f5_done", 32'(done), 32'd0);
        chk("f5_err", 32'(err), 32'd1);
        chk_wr("f5", 12'h000, 1);
        // Next good frame clears err.
        wa.delete(); wd.delete();
        dbuf[0] = 8'h66;
        run_frame(12'h100, 4'h0, 8'h00, 1'b0, 8'h00);
        chk_fin("f6");
        chk("f6_done", 32'(done), 32'd1);
        chk("f6_err", 32'(err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
